// File: rtl/if_prefetch_stage_pkg.sv
// Shared types for the instruction-fetch stage.
// Holds the prefetch queue entry layout and fetch constants.
package if_prefetch_stage_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear, used for the prefetch and tag queues.
// Depth need not be a power of two; pointers wrap explicitly.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A full queue may still accept a push when the head leaves this cycle
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with prefetch queue, credit-limited req/gnt issue
// and redirect/flush handling that drops stale in-flight responses.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              QUEUE_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_op,
    output logic [XLEN-1:0] imem_addr_op,
    input  logic            imem_gnt_ip,
    input  logic            imem_rvalid_ip,
    input  logic [XLEN-1:0] imem_rdata_ip,
    input  logic            redirect_valid_ip,
    input  logic [XLEN-1:0] redirect_pc_ip,
    input  logic            flush_ip,
    input  logic            stall_ip,
    output logic            instr_valid_op,
    output logic [XLEN-1:0] instr_data_op,
    output logic [XLEN-1:0] instr_pc_addr_op
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic            tag_full;
    logic            tag_empty;
    logic [XLEN-1:0] tag_pc;
    logic            restart;
    logic            credit_ok;
    logic            fire;
    logic            q_push;
    logic            q_pop;
    fetch_entry_t    q_in;
    fetch_entry_t    q_head;
    logic            unused;

    assign restart   = redirect_valid_ip | flush_ip;
    assign credit_ok = (int'(q_count) + int'(outstanding) < QUEUE_DEPTH)
                     && (int'(outstanding) < MAX_OUTSTANDING);

    assign imem_req_op  = ~reset & ~restart & credit_ok;
    assign imem_addr_op = fetch_pc;
    assign fire         = imem_req_op & imem_gnt_ip;

    // The tag queue occupancy is the outstanding-request count
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clock     (clock),
        .reset     (reset),
        .clear     (1'b0),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (imem_rvalid_ip),
        .pop_data  (tag_pc),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign q_in.pc    = tag_pc;
    assign q_in.instr = imem_rdata_ip;
    assign q_push = imem_rvalid_ip & (discard == '0) & ~restart;
    assign q_pop  = instr_valid_op & ~stall_ip & ~restart;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_prefetch_q (
        .clock     (clock),
        .reset     (reset),
        .clear     (restart),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign instr_valid_op   = ~q_empty;
    assign instr_data_op    = instr_valid_op ? q_head.instr : '0;
    assign instr_pc_addr_op = instr_valid_op ? q_head.pc : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid_ip) begin
            fetch_pc <= {redirect_pc_ip[XLEN-1:2], 2'b00};
        end else if (fire) begin
            fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        end
    end

    // On restart every response still in flight is stale
    always_ff @(posedge clock) begin
        if (reset) begin
            discard <= '0;
        end else if (restart) begin
            discard <= outstanding - OW'(imem_rvalid_ip);
        end else if (imem_rvalid_ip && discard != '0) begin
            discard <= discard - 1'b1;
        end
    end

    assign unused = ^{q_full, tag_full, tag_empty, redirect_pc_ip[1:0]};

endmodule
